// File: rtl/data_mem_be_if.sv
// data_mem_be_if: request/response bus between the memory stage and data_mem_be
interface data_mem_be_if #(parameter int AW = 10);
  logic req_valid;
  logic req_we;
  logic [AW-1:0] req_addr;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [31:0] wdata;
  logic ready;
  logic busy;
  logic rdata_valid;
  logic [31:0] rdata;
  logic err;
  modport master(
    output req_valid, req_we, req_addr, req_size, req_unsigned, wdata,
    input ready, busy, rdata_valid, rdata, err
  );
  modport slave(
    input req_valid, req_we, req_addr, req_size, req_unsigned, wdata,
    output ready, busy, rdata_valid, rdata, err
  );
endinterface

// File: rtl/data_mem_be.sv
// data_mem_be: byte-lane data memory with sized loads/stores, registered read and reset clear sweep
module data_mem_be #(
  parameter int DEPTH = 256,
  parameter bit CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic rst,
  data_mem_be_if.slave bus
);
  localparam int AW = $clog2(DEPTH) + 2;
  localparam int PW = AW - 2;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, nxt;
  logic [PW-1:0] clr_ptr, idx;
  logic [1:0] lane;
  logic acc, mis;
  logic [3:0] be;
  logic [31:0] wd, sh, ld;
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr <= '0;
    end else begin
      state <= nxt;
      clr_ptr <= state == CLEAR ? clr_ptr + 1'b1 : clr_ptr;
    end
  end
  always_comb nxt = (state == CLEAR && clr_ptr == PW'(DEPTH - 1)) ? IDLE : state;
  always_comb begin
    bus.busy = state == CLEAR;
    bus.ready = state == IDLE;
  end
  always_comb begin
    idx = bus.req_addr[AW-1:2];
    lane = bus.req_addr[1:0];
    acc = bus.req_valid && state == IDLE && !rst;
    mis = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && lane[0]) ||
          (bus.req_size == 2'b10 && lane != 2'b00);
    be = bus.req_size == 2'b00 ? 4'b0001 << lane :
         bus.req_size == 2'b01 ? 4'b0011 << {lane[1], 1'b0} : 4'hf;
    wd = bus.req_size == 2'b00 ? {4{bus.wdata[7:0]}} :
         bus.req_size == 2'b01 ? {2{bus.wdata[15:0]}} : bus.wdata;
    sh = mem[idx] >> {lane, 3'b000};
    ld = bus.req_size == 2'b10 ? sh :
         bus.req_size == 2'b01 ? {{16{sh[15] & ~bus.req_unsigned}}, sh[15:0]} :
                                 {{24{sh[7] & ~bus.req_unsigned}}, sh[7:0]};
  end
  // stores commit at the acceptance edge, so a following load sees them without forwarding
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_ptr] <= '0;
    else if (acc && bus.req_we && !mis)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata_valid <= 1'b0;
      bus.err <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.rdata_valid <= acc && !bus.req_we;
      bus.err <= acc && mis;
      if (acc && !bus.req_we) bus.rdata <= mis ? '0 : ld;
    end
  end
endmodule
